vco_freq_ctrl: RTL
==================

# vco_freq_ctrl

Digital frequency-lock controller sitting directly upstream of `vco`: it drives the VCO's `voltage_ctrl_i` word. The block counts VCO rising edges over a fixed gate window of reference clock cycles and compares the count with a programmed target. It then applies a saturating proportional correction to the control word. It reports lock once the measured count stays within tolerance for several consecutive windows.

## Interface
- `RESOLUTION_BITS`, 30: width of the control word; matches `vco`.
- `COUNT_BITS`, 16: width of edge count and target.
- `WINDOW_CYCLES`, 1024: gate window length in `clk_i` cycles, ≥ 4.
- `KP_SHIFT`, 4: proportional gain; the correction equals the error shifted left by this amount.
- `TOLERANCE`, 1: lock deadband in counts.
- `LOCK_WINDOWS`, 4: consecutive in-tolerance windows required to assert lock.
- `INIT_CTRL`, 0: reset and idle value of the control word.
- `clk_i` input 1: reference clock; the only clock.
- `rst_i` input 1: synchronous, active-high reset.
- `en_i` input 1: run enable.
- `target_count_i` input COUNT_BITS: desired edges per window; sampled at each window start.
- `vco_clk_i` input 1: VCO output, treated as an asynchronous data input; requires f_vco < f_clk/2.
- `voltage_ctrl_o` output RESOLUTION_BITS: control word to `vco.voltage_ctrl_i`.
- `meas_count_o` output COUNT_BITS: last completed window count.
- `meas_valid_o` output 1: one-cycle pulse when `meas_count_o` updates.
- `locked_o` output 1: lock indicator.

## Operation
- **Input synchronisation:** `vco_clk_i` passes through a 2-flop synchroniser, then a rising-edge detector (third flop).
- **States:**
  - IDLE: counters cleared, `voltage_ctrl_o` = INIT_CTRL, `locked_o` = 0. Moves to MEASURE when `en_i` = 1.
  - MEASURE: window counter runs 0..WINDOW_CYCLES-1; the edge counter increments on each detected edge and saturates at 2^COUNT_BITS-1. On the last window cycle, go to UPDATE.
  - UPDATE: one cycle. Return to MEASURE with both counters at 0.
- **Window boundaries:** an edge detected on the last MEASURE cycle counts in that window. No edges are counted during UPDATE; that cycle is a blanking cycle.
- **Error:** `err = target - count`, signed, COUNT_BITS+1 wide.
- **In tolerance (|err| ≤ TOLERANCE):** no correction; the lock counter increments, saturating at LOCK_WINDOWS.
- **Out of tolerance:** `voltage_ctrl_o += err <<< KP_SHIFT`. The sum is computed at RESOLUTION_BITS+COUNT_BITS+KP_SHIFT+1 bits and clamped to [0, 2^RESOLUTION_BITS-1]. The lock counter clears.
- **Lock:** `locked_o` = 1 while the lock counter equals LOCK_WINDOWS.
- **Disable:** `en_i` = 0 in any state goes to IDLE on the next cycle. Any partial window is discarded, with no `meas_valid_o` pulse.
- **Target sampling:** the target is latched on entry to MEASURE. Changes mid-window take effect in the next window.

## Timing
- **Reset values:** `voltage_ctrl_o` = INIT_CTRL, `meas_count_o` = 0, `meas_valid_o` = 0, `locked_o` = 0, state IDLE. Asserting `rst_i` mid-window has the same effect.
- **Edge latency:** 3 `clk_i` cycles from a `vco_clk_i` rise to the edge being counted.
- **UPDATE cycle outputs:** registered at the end of UPDATE, so all appear on the cycle after UPDATE:
  - `meas_count_o` updates and `meas_valid_o` pulses.
  - `voltage_ctrl_o` updates in that same cycle.
  - `locked_o` updates in that same cycle.
- **Measurement period:** WINDOW_CYCLES+1 `clk_i` cycles.
- **Control word stability:** `voltage_ctrl_o` is stable for the whole measurement period between updates.

## Structure
- **Package `vco_freq_ctrl_pkg`:** the state enum (IDLE, MEASURE, UPDATE) and a saturating add/clamp function.
- **Sub-module `vco_edge_counter`:** synchroniser, edge detector and saturating counter, with `clear_i`/`count_en_i` inputs and a `count_o` output.
- **Top level:** the FSM, window counter, error/correction datapath and lock counter.

## Test plan
- **Steady match:** clk 10 ns, `vco_clk_i` period 40 ns, target 256 → every `meas_count_o` = 256, `voltage_ctrl_o` stays 0, `locked_o` rises after the 4th `meas_valid_o`.
- **Upward correction:** same stimulus, target 300 → err +44, `voltage_ctrl_o` goes 0 → 704 after the first window, 1408 after the second, and `locked_o` stays 0.
- **Clamps:**
  - INIT_CTRL = 0, target 0, `vco_clk_i` running → `voltage_ctrl_o` clamps at 0.
  - INIT_CTRL = 2^30-16, target 400, count 256 → `voltage_ctrl_o` clamps at 2^30-1.
- **Lock loss:** locked at target 256, then `vco_clk_i` period changes to 50 ns → next `meas_count_o` ≈ 204, `locked_o` drops on that `meas_valid_o`, and the relock count restarts.
- **Count saturation:** COUNT_BITS = 8, 4 edges per 10 cycles → `meas_count_o` = 255.
- **Abort/reset:**
  - `en_i` low at window cycle 500 → no `meas_valid_o`, `voltage_ctrl_o` = INIT_CTRL next cycle; re-enabling starts a full fresh window.
  - `rst_i` pulsed mid-window → all outputs at reset values one cycle later.

Source files
------------

// File: rtl/vco_freq_ctrl_pkg.sv
// Shared types and helpers for the VCO frequency-lock controller.
`timescale 1ns/1ps
package vco_freq_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StUpdate
  } state_e;

  // Clamp a signed sum into the unsigned range [0, 2^res_bits-1].
  function automatic logic [63:0] clamp_word(input logic signed [63:0] sum,
                                             input int unsigned res_bits);
    logic [63:0] max_v;
    max_v = (64'd1 << res_bits) - 64'd1;
    if (sum < 64'sd0) begin
      return '0;
    end else if (sum > $signed(max_v)) begin
      return max_v;
    end else begin
      return $unsigned(sum);
    end
  endfunction

endpackage

// File: rtl/vco_edge_counter.sv
// Synchronises the VCO clock, detects its rising edges and counts them.
`timescale 1ns/1ps
module vco_edge_counter #(
  parameter int unsigned COUNT_BITS = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  vco_clk_i,
  input  logic                  clear_i,
  input  logic                  count_en_i,
  output logic [COUNT_BITS-1:0] count_o
);

  // [0],[1] form the synchroniser; [2] holds the previous synchronised sample.
  logic [2:0] sync_q;
  logic       rise;

  // Shift the asynchronous VCO level through the synchroniser chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], vco_clk_i};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

  // Count detected edges, holding at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_o <= '0;
    end else if (count_en_i && rise && (count_o != '1)) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/vco_freq_ctrl.sv
// Frequency-lock controller: gated edge count, proportional correction, lock detect.
`timescale 1ns/1ps
module vco_freq_ctrl
  import vco_freq_ctrl_pkg::*;
#(
  parameter int unsigned               RESOLUTION_BITS = 30,
  parameter int unsigned               COUNT_BITS      = 16,
  parameter int unsigned               WINDOW_CYCLES   = 1024,
  parameter int unsigned               KP_SHIFT        = 4,
  parameter int unsigned               TOLERANCE       = 1,
  parameter int unsigned               LOCK_WINDOWS    = 4,
  parameter logic [RESOLUTION_BITS-1:0] INIT_CTRL      = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [COUNT_BITS-1:0]      target_count_i,
  input  logic                       vco_clk_i,
  output logic [RESOLUTION_BITS-1:0] voltage_ctrl_o,
  output logic [COUNT_BITS-1:0]      meas_count_o,
  output logic                       meas_valid_o,
  output logic                       locked_o
);

  localparam int unsigned WinW  = $clog2(WINDOW_CYCLES);
  localparam int unsigned LockW = $clog2(LOCK_WINDOWS + 1);
  localparam int unsigned SumW  = RESOLUTION_BITS + COUNT_BITS + KP_SHIFT + 1;
  localparam logic signed [COUNT_BITS:0] TolS = (COUNT_BITS + 1)'(TOLERANCE);

  state_e                       state_q, state_d;
  logic [WinW-1:0]              win_q, win_d;
  logic [COUNT_BITS-1:0]        target_q, target_d;
  logic [RESOLUTION_BITS-1:0]   ctrl_q, ctrl_d;
  logic [COUNT_BITS-1:0]        meas_q, meas_d;
  logic                         valid_q, valid_d;
  logic [LockW-1:0]             lock_q, lock_d;

  logic                         cnt_clear, cnt_en;
  logic [COUNT_BITS-1:0]        edge_count;
  logic signed [COUNT_BITS:0]   err;
  logic signed [SumW-1:0]       corr, sum;
  logic                         in_tol;

  vco_edge_counter #(
    .COUNT_BITS (COUNT_BITS)
  ) u_edge_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .vco_clk_i  (vco_clk_i),
    .clear_i    (cnt_clear),
    .count_en_i (cnt_en),
    .count_o    (edge_count)
  );

  // Error and clamped proportional correction for the window just closed.
  always_comb begin
    err    = $signed({1'b0, target_q}) - $signed({1'b0, edge_count});
    corr   = {{(SumW - COUNT_BITS - 1){err[COUNT_BITS]}}, err};
    corr   = corr <<< KP_SHIFT;
    sum    = $signed({{(SumW - RESOLUTION_BITS){1'b0}}, ctrl_q}) + corr;
    in_tol = (err <= TolS) && (err >= -TolS);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    win_d     = '0;
    target_d  = target_q;
    ctrl_d    = ctrl_q;
    meas_d    = meas_q;
    valid_d   = 1'b0;
    lock_d    = lock_q;
    cnt_clear = 1'b1;
    cnt_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        ctrl_d = INIT_CTRL;
        lock_d = '0;
        if (en_i) begin
          state_d  = StMeasure;
          target_d = target_count_i;
        end
      end
      StMeasure: begin
        cnt_clear = 1'b0;
        cnt_en    = 1'b1;
        win_d     = win_q + 1'b1;
        if (win_q == WinW'(WINDOW_CYCLES - 1)) begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        // Blanking cycle: the counter is cleared while its final value is consumed.
        meas_d   = edge_count;
        valid_d  = 1'b1;
        state_d  = StMeasure;
        target_d = target_count_i;
        if (in_tol) begin
          if (lock_q != LockW'(LOCK_WINDOWS)) begin
            lock_d = lock_q + 1'b1;
          end
        end else begin
          lock_d = '0;
          ctrl_d = RESOLUTION_BITS'(clamp_word({{(64 - SumW){sum[SumW-1]}}, sum},
                                               RESOLUTION_BITS));
        end
      end
      default: state_d = StIdle;
    endcase

    // Disable wins over everything and throws away the partial window.
    if (!en_i) begin
      state_d  = StIdle;
      win_d    = '0;
      ctrl_d   = INIT_CTRL;
      meas_d   = meas_q;
      valid_d  = 1'b0;
      lock_d   = '0;
      target_d = target_q;
      cnt_clear = 1'b1;
      cnt_en    = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      win_q    <= '0;
      target_q <= '0;
      ctrl_q   <= INIT_CTRL;
      meas_q   <= '0;
      valid_q  <= 1'b0;
      lock_q   <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      target_q <= target_d;
      ctrl_q   <= ctrl_d;
      meas_q   <= meas_d;
      valid_q  <= valid_d;
      lock_q   <= lock_d;
    end
  end

  assign voltage_ctrl_o = ctrl_q;
  assign meas_count_o   = meas_q;
  assign meas_valid_o   = valid_q;
  assign locked_o       = (lock_q == LockW'(LOCK_WINDOWS));

endmodule
